// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the fetch/data memory port arbiter.
// State encoding, owner codes and the starve counter width.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        DONE   = 2'd3
    } state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    localparam int unsigned STARVE_W = 3;

endpackage

// File: rtl/arb_pick.sv
// arb_pick: combinational winner select for the memory port.
// Data wins ties unless the starve limit hands the slot to fetch.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic   if_req,
    input  logic   d_req,
    input  logic   starve_hit,
    output logic   grant,
    output owner_e winner
);

    // Older MEM-stage access first; a starved fetch may jump ahead.
    always_comb begin
        grant  = if_req | d_req;
        winner = OWN_D;
        if (if_req && (!d_req || starve_hit)) begin
            winner = OWN_I;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between IF fetch and MEM load/store.
// Build option MEM_ARB_FAIRNESS_EN bounds fetch starvation behind data grants.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    input  logic          flush,
    output logic          stall_if,
    output logic          stall_d,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready
);

    state_e        state_q, state_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          if_ack_q, if_ack_d;
    logic          d_ack_q, d_ack_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          drop_q, drop_d;
    logic          grant;
    owner_e        winner;
    logic          starve_hit;

    arb_pick u_pick (
        .if_req     (if_req),
        .d_req      (d_req),
        .starve_hit (starve_hit),
        .grant      (grant),
        .winner     (winner)
    );

`ifdef MEM_ARB_FAIRNESS_EN
    logic [STARVE_W-1:0] starve_q, starve_d;

    assign starve_hit = (starve_q == STARVE_W'(STARVE_MAX));

    // Count data grants that bypass a waiting fetch; a fetch grant clears.
    always_comb begin
        starve_d = starve_q;
        if (state_q == IDLE && grant) begin
            if (winner == OWN_I) begin
                starve_d = '0;
            end else if (if_req && starve_q != '1) begin
                starve_d = starve_q + STARVE_W'(1);
            end
        end
    end

    // Starve counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    logic unused_starve_max;

    assign starve_hit        = 1'b0;
    assign unused_starve_max = (STARVE_W'(STARVE_MAX) != '0);
`endif

    // Next state: grant in IDLE, hold the handshake, pulse ack in DONE.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        drop_d      = drop_q;
        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    mem_req_d = 1'b1;
                    if (winner == OWN_D) begin
                        state_d     = BUSY_D;
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                    end else begin
                        state_d    = BUSY_I;
                        mem_we_d   = 1'b0;
                        mem_addr_d = if_addr;
                    end
                end
            end
            BUSY_I: begin
                drop_d = drop_q | flush;
                if (mem_ready) begin
                    if_rdata_d = mem_rdata;
                    if_ack_d   = !(drop_q || flush);
                    mem_req_d  = 1'b0;
                    mem_we_d   = 1'b0;
                    state_d    = DONE;
                end
            end
            BUSY_D: begin
                if (mem_ready) begin
                    if (!mem_we_q) begin
                        d_rdata_d = mem_rdata;
                    end
                    d_ack_d   = 1'b1;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = DONE;
                end
            end
            DONE: begin
                drop_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Arbiter state and registered memory/requester outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            drop_q      <= drop_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_ack    = if_ack_q;
    assign d_ack     = d_ack_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign stall_if  = if_req & ~if_ack_q;
    assign stall_d   = d_req & ~d_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random checks of the memory port arbiter.
// Memory responder with programmable latency; reference memory for read data.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        flush = 1'b0;
    logic        stall_if;
    logic        stall_d;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;

    mem_port_arbiter #(
        .AW(32), .DW(32), .STARVE_MAX(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .flush     (flush),
        .stall_if  (stall_if),
        .stall_d   (stall_d),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err = 0;

    // Memory responder configuration and contents.
    int lat_cfg = 0;
    bit tie_ready = 1'b0;
    logic [31:0] mem [logic [31:0]];
    bit busy = 1'b0;
    int cnt = 0;
    int cur_lat = 0;

    // Reference model memory, updated on each store completion.
    logic [31:0] model_mem [logic [31:0]];

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, ~a[15:0]};
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return init_val(a);
    endfunction

    function automatic logic [31:0] mdl_rd(input logic [31:0] a);
        if (model_mem.exists(a)) return model_mem[a];
        return init_val(a);
    endfunction

    // Memory responder: ready after lat cycles of mem_req, or tied high.
    always @(negedge clk) begin
        if (tie_ready) begin
            mem_ready = 1'b1;
            mem_rdata = mem_rd(mem_addr);
            if (mem_req && mem_we) mem[mem_addr] = mem_wdata;
        end else if (mem_req && !mem_ready) begin
            if (!busy) begin
                busy = 1'b1;
                cnt = 0;
                cur_lat = (lat_cfg < 0) ? int'($urandom_range(0, 3)) : lat_cfg;
            end
            if (cnt >= cur_lat) begin
                mem_ready = 1'b1;
                mem_rdata = mem_rd(mem_addr);
                if (mem_we) mem[mem_addr] = mem_wdata;
            end else begin
                cnt++;
            end
        end else begin
            mem_ready = 1'b0;
            busy = 1'b0;
            mem_rdata = $urandom;
        end
    end

    task automatic chkb(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %b want %b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic wait_any(input int max, output bit gi, output bit gd,
                            output int cyc);
        gi = 1'b0;
        gd = 1'b0;
        cyc = 0;
        for (int i = 1; i <= max; i++) begin
            @(negedge clk);
            if (if_ack || d_ack) begin
                gi = if_ack;
                gd = d_ack;
                cyc = i;
                break;
            end
        end
        chkb("ack_in_time", gi | gd, 1'b1);
    endtask

    task automatic wait_req_low(input int max);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (!mem_req) begin
                ok = 1'b1;
                break;
            end
        end
        chkb("req_low_in_time", ok, 1'b1);
    endtask

    // Random-phase requester state.
    bit ip = 1'b0;
    bit dp = 1'b0;
    bit dwe = 1'b0;
    logic [31:0] ia = '0;
    logic [31:0] da = '0;
    logic [31:0] dw = '0;
    bit prev_mreq = 1'b0;
    logic [31:0] held_a = '0;

    task automatic rnd_cycle(input bit allow_new);
        bit is_d;
        bit is_i;
        @(negedge clk);
        if (mem_req && !prev_mreq) begin
            is_d = d_req && mem_addr == d_addr && mem_we == d_we &&
                   (!d_we || mem_wdata == d_wdata);
            is_i = if_req && mem_addr == if_addr && !mem_we;
`ifdef MEM_ARB_FAIRNESS_EN
            chkb("rnd_grant", is_d | is_i, 1'b1);
`else
            chkb("rnd_grant", d_req ? is_d : is_i, 1'b1);
`endif
            held_a = mem_addr;
        end else if (mem_req) begin
            chkw("rnd_addr_hold", mem_addr, held_a);
        end
        prev_mreq = mem_req;
        chkb("rnd_ack_excl", if_ack & d_ack, 1'b0);
        if (if_ack) begin
            chkb("rnd_if_owner", ip, 1'b1);
            chkw("rnd_if_data", if_rdata, mdl_rd(ia));
            ip = 1'b0;
            if_req = 1'b0;
        end
        if (d_ack) begin
            chkb("rnd_d_owner", dp, 1'b1);
            if (!dwe) chkw("rnd_d_data", d_rdata, mdl_rd(da));
            else model_mem[da] = dw;
            dp = 1'b0;
            d_req = 1'b0;
        end
        if (allow_new && !ip && $urandom_range(0, 2) == 0) begin
            ip = 1'b1;
            ia = 32'h300 + 4 * $urandom_range(0, 7);
            if_req = 1'b1;
            if_addr = ia;
        end
        if (allow_new && !dp && $urandom_range(0, 2) == 0) begin
            dp = 1'b1;
            da = 32'h300 + 4 * $urandom_range(0, 7);
            dwe = 1'($urandom_range(0, 1));
            dw = $urandom;
            d_req = 1'b1;
            d_we = dwe;
            d_addr = da;
            d_wdata = dw;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit gi;
        bit gd;
        bit got_f;
        int cyc;
        int n_d;

        // Reset state.
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chkb("rst_mem_req", mem_req, 1'b0);
        chkb("rst_mem_we", mem_we, 1'b0);
        chkw("rst_mem_addr", mem_addr, 32'h0);
        chkw("rst_mem_wdata", mem_wdata, 32'h0);
        chkb("rst_if_ack", if_ack, 1'b0);
        chkb("rst_d_ack", d_ack, 1'b0);
        chkw("rst_if_rdata", if_rdata, 32'h0);
        chkw("rst_d_rdata", d_rdata, 32'h0);
        rst = 1'b1;

        // Single fetch with two wait cycles.
        lat_cfg = 2;
        mem[32'h40] = 32'h8C22_0004;
        @(negedge clk);
        if_req = 1'b1;
        if_addr = 32'h40;
        #1 chkb("s1_stall_req", stall_if, 1'b1);
        @(negedge clk);
        chkb("s1_mem_req", mem_req, 1'b1);
        chkw("s1_mem_addr", mem_addr, 32'h40);
        chkb("s1_mem_we", mem_we, 1'b0);
        chkb("s1_stall_wait", stall_if, 1'b1);
        wait_any(20, gi, gd, cyc);
        chkw("s1_latency", cyc, 3);
        chkb("s1_if_ack", gi, 1'b1);
        chkb("s1_no_d_ack", gd, 1'b0);
        chkw("s1_if_rdata", if_rdata, 32'h8C22_0004);
        chkb("s1_stall_ack", stall_if, 1'b0);
        if_req = 1'b0;
        @(negedge clk);
        chkb("s1_ack_width", if_ack, 1'b0);
        repeat (2) @(negedge clk);
        chkb("s1_no_reservice", mem_req, 1'b0);

        // Simultaneous requests: store goes first, then fetch.
        lat_cfg = 1;
        d_req = 1'b1;
        d_we = 1'b1;
        d_addr = 32'h100;
        d_wdata = 32'hDEAD_BEEF;
        if_req = 1'b1;
        if_addr = 32'h44;
        @(negedge clk);
        chkb("s2_d_grant_req", mem_req, 1'b1);
        chkb("s2_d_grant_we", mem_we, 1'b1);
        chkw("s2_d_grant_addr", mem_addr, 32'h100);
        chkw("s2_d_grant_wdata", mem_wdata, 32'hDEAD_BEEF);
        chkb("s2_stall_d", stall_d, 1'b1);
        wait_any(20, gi, gd, cyc);
        chkb("s2_first_d", gd, 1'b1);
        chkb("s2_first_not_i", gi, 1'b0);
        d_req = 1'b0;
        d_we = 1'b0;
        repeat (2) @(negedge clk);
        chkb("s2_i_grant_req", mem_req, 1'b1);
        chkw("s2_i_grant_addr", mem_addr, 32'h44);
        chkb("s2_i_grant_we", mem_we, 1'b0);
        wait_any(20, gi, gd, cyc);
        chkb("s2_second_i", gi, 1'b1);
        chkw("s2_if_rdata", if_rdata, init_val(32'h44));
        chkw("s2_d_rdata_kept", d_rdata, 32'h0);
        if_req = 1'b0;

        // Flush during a fetch drops its ack; redirected fetch proceeds.
        lat_cfg = 3;
        @(negedge clk);
        if_req = 1'b1;
        if_addr = 32'h80;
        @(negedge clk);
        chkb("s3_busy_i", mem_req, 1'b1);
        flush = 1'b1;
        if_addr = 32'h84;
        @(negedge clk);
        flush = 1'b0;
        chkw("s3_addr_latched", mem_addr, 32'h80);
        wait_req_low(20);
        chkb("s3_ack_dropped", if_ack, 1'b0);
        chkw("s3_rdata_upd", if_rdata, init_val(32'h80));
        wait_any(20, gi, gd, cyc);
        chkb("s3_next_ack", gi, 1'b1);
        chkw("s3_next_rdata", if_rdata, init_val(32'h84));
        if_req = 1'b0;

        // Reset in the middle of a load.
        lat_cfg = 5;
        @(negedge clk);
        d_req = 1'b1;
        d_we = 1'b0;
        d_addr = 32'h200;
        @(negedge clk);
        chkb("s4_busy_d", mem_req, 1'b1);
        chkw("s4_busy_addr", mem_addr, 32'h200);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 chkb("s4_async_req", mem_req, 1'b0);
        @(negedge clk);
        chkb("s4_no_d_ack", d_ack, 1'b0);
        chkw("s4_if_rdata_clr", if_rdata, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        chkb("s4_regrant", mem_req, 1'b1);
        chkw("s4_regrant_addr", mem_addr, 32'h200);
        wait_any(20, gi, gd, cyc);
        chkb("s4_d_ack", gd, 1'b1);
        chkw("s4_d_rdata", d_rdata, init_val(32'h200));
        d_req = 1'b0;
        @(negedge clk);

        // Zero-wait memory, back-to-back loads.
        tie_ready = 1'b1;
        d_req = 1'b1;
        d_we = 1'b0;
        d_addr = 32'h100;
        for (int k = 0; k < 4; k++) begin
            wait_any(10, gi, gd, cyc);
            chkb("s5_d_ack", gd, 1'b1);
            chkw("s5_spacing", cyc, (k == 0) ? 2 : 3);
            chkw("s5_d_rdata", d_rdata,
                 (k == 0) ? 32'hDEAD_BEEF : init_val(32'h100 + 4 * k));
            chkb("s5_stall_d", stall_d, 1'b0);
            d_addr = 32'h100 + 4 * (k + 1);
        end
        d_req = 1'b0;
        @(negedge clk);
        chkb("s5_last_width", d_ack, 1'b0);
        tie_ready = 1'b0;
        @(negedge clk);

        // Continuous loads with a fetch waiting behind them.
        lat_cfg = 0;
        d_req = 1'b1;
        d_we = 1'b0;
        d_addr = 32'h300;
        if_req = 1'b1;
        if_addr = 32'h48;
        n_d = 0;
        got_f = 1'b0;
        for (int k = 0; k < 8; k++) begin
            wait_any(20, gi, gd, cyc);
            if (gd) n_d++;
            if (gi) begin
                got_f = 1'b1;
                break;
            end
        end
`ifdef MEM_ARB_FAIRNESS_EN
        chkb("s6_fetch_granted", got_f, 1'b1);
        chkw("s6_data_before", n_d, 4);
`else
        chkb("s6_fetch_starved", got_f, 1'b0);
        chkw("s6_data_before", n_d, 8);
`endif
        d_req = 1'b0;
        if (!got_f) begin
            wait_any(20, gi, gd, cyc);
            chkb("s6_fetch_after", gi, 1'b1);
        end
        chkw("s6_if_rdata", if_rdata, init_val(32'h48));
        if_req = 1'b0;
        repeat (2) @(negedge clk);

        // Random traffic against the reference memory.
        lat_cfg = -1;
        prev_mreq = mem_req;
        for (int k = 0; k < 400; k++) rnd_cycle(1'b1);
        for (int k = 0; k < 100 && (ip || dp); k++) rnd_cycle(1'b0);
        chkb("rnd_drained", ip | dp, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified instruction/data memory between the IF stage (fetch) and the MEM stage (load/store) of the pipelined MIPS core.
- Grants one requester at a time and holds the memory handshake until the memory responds.
- Returns a registered read data/ack pulse to the granted requester.
- Drives stall_if/stall_d to the pipeline controller; flush drops an in-flight fetch result.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- STARVE_MAX, 4, consecutive data grants tolerated while a fetch waits (MEM_ARB_FAIRNESS_EN only).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request, level, held until if_ack.
- if_addr  in  AW  fetch address.
- if_ack  out  1  one-cycle fetch-complete pulse.
- if_rdata  out  DW  fetch data, valid with if_ack.
- d_req  in  1  data request, level, held until d_ack.
- d_we  in  1  1=store, 0=load.
- d_addr  in  AW  data address.
- d_wdata  in  DW  store data.
- d_ack  out  1  one-cycle data-complete pulse.
- d_rdata  out  DW  load data, valid with d_ack.
- flush  in  1  branch/jump flush from the controller.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data.
- mem_ready  in  1  memory completion, valid only while mem_req=1.

Behaviour:
- Reset (rst=0, async): state=IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0; if_ack=0, d_ack=0, if_rdata=0, d_rdata=0; drop flag=0; starve count=0. Any in-flight transaction is abandoned and no ack follows.
- States: IDLE, BUSY_I, BUSY_D, DONE.
- IDLE:
  - d_req=1 -> BUSY_D. Data wins ties because the MEM-stage instruction is older.
  - Otherwise if_req=1 -> BUSY_I.
  - On entry to BUSY_x, the mem_* outputs are registered from the winner's inputs and stay constant until completion. mem_we is 0 for fetches.
- BUSY_x:
  - mem_req=1; wait for mem_ready. Memory latency is unbounded.
  - On mem_ready: capture mem_rdata into the owner's rdata register (loads and fetches only), drop mem_req, go to DONE.
- DONE:
  - Owner's ack=1 for exactly this cycle, then IDLE.
  - No arbitration occurs in DONE, so a requester that deasserts req after seeing ack is never serviced twice.
  - Minimum transaction: 3 cycles (grant, ready, ack) with zero-wait memory.
- Flush:
  - In BUSY_I, or in the mem_ready cycle of BUSY_I, set drop. The transaction completes on the memory side, but if_ack is suppressed in DONE; if_rdata still updates.
  - drop clears on leaving DONE.
  - Flush in IDLE, BUSY_D, or DONE-of-data has no effect.
- A store updates no rdata register. d_rdata holds its last load value.
- Stalls (combinational): stall_if = if_req & ~if_ack; stall_d = d_req & ~d_ack.
- Requester inputs changing mid-transaction are ignored; the mem_* outputs are latched.
- mem_ready while mem_req=0 is ignored.

Optional Feature:
- Macro MEM_ARB_FAIRNESS_EN.
- Defined:
  - A 3-bit starve counter increments on each data grant made while if_req=1, and clears on any fetch grant.
  - When the count equals STARVE_MAX and both requests are present in IDLE, fetch wins.
- Undefined: strict data priority; no counter logic is present.

Decomposition:
- Package mem_arb_pkg: state encoding localparams (IDLE=2'd0, BUSY_I=2'd1, BUSY_D=2'd2, DONE=2'd3) and owner codes (OWN_I, OWN_D).
- Sub-module arb_pick: combinational winner select from if_req, d_req, and the starve-limit flag. Natural because the fairness variant changes only this function.

Test Plan:
- Single fetch, if_addr=0x40, memory ready 2 cycles after mem_req -> mem_addr=0x40, mem_we=0; if_ack pulses 1 cycle with if_rdata=mem_rdata (e.g. 0x8C220004); stall_if high until then.
- if_req and d_req both rise in the same cycle; d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF -> data served first (mem_we=1, mem_addr=0x100), then the fetch; d_ack precedes if_ack.
- flush pulsed during BUSY_I -> memory handshake completes, if_ack stays 0, next fetch granted normally.
- rst low during BUSY_D -> mem_req=0 immediately (async), no d_ack; after release, state is IDLE and a new request is granted.
- Zero-wait memory (mem_ready tied 1), continuous d_req with back-to-back loads -> one completion every 3 cycles, each d_ack exactly 1 cycle wide, no duplicate service.
- MEM_ARB_FAIRNESS_EN, STARVE_MAX=4, d_req continuously high plus if_req held -> after 4 data grants a fetch is granted; without the macro, the fetch is never granted while d_req stays high.
